// File: rtl/axis_fifo_ctrl.sv
// AXI-Stream FIFO controller for an external 1-cycle-latency dual-port RAM.
// Optional tlast path: define AXIS_FIFO_TLAST_EN.
module axis_fifo_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
`ifdef AXIS_FIFO_TLAST_EN
  localparam int RAM_WIDTH = DATA_WIDTH + 1
`else
  localparam int RAM_WIDTH = DATA_WIDTH
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
`ifdef AXIS_FIFO_TLAST_EN
  input  logic                  s_axis_tlast,
  output logic                  m_axis_tlast,
`endif
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [RAM_WIDTH-1:0]  ram_din,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [RAM_WIDTH-1:0]  ram_dout,
  output logic [ADDR_WIDTH+1:0] level
);

  localparam logic [ADDR_WIDTH:0] FULL =
    {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   wr_nx, rd_nx;
  logic [ADDR_WIDTH:0]   ram_cnt, cnt_nx;
  logic [ADDR_WIDTH+1:0] level_nx;
  logic [RAM_WIDTH-1:0]  out0, out1;
  logic [1:0]            outcnt, outcnt_nx;
  logic [2:0]            occ;
  logic                  rd_pend, rdy_en;
  logic                  push, pop, issue, land_hi;

  assign ram_cnt       = wr_ptr - rd_ptr;
  assign s_axis_tready = rdy_en & (ram_cnt != FULL);
  assign m_axis_tvalid = (outcnt != 2'd0);
  assign push          = s_axis_tvalid & s_axis_tready;
  assign pop           = m_axis_tvalid & m_axis_tready;

  assign ram_we    = push;
  assign ram_waddr = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_raddr = rd_ptr[ADDR_WIDTH-1:0];
`ifdef AXIS_FIFO_TLAST_EN
  assign ram_din      = {s_axis_tlast, s_axis_tdata};
  assign m_axis_tlast = out0[DATA_WIDTH];
`else
  assign ram_din      = s_axis_tdata;
`endif
  assign m_axis_tdata = out0[DATA_WIDTH-1:0];

  // Beats in or heading to the output buffer after this cycle's pop
  always_comb begin
    occ = {1'b0, outcnt} + {2'b0, rd_pend} - {2'b0, pop};
    issue = (ram_cnt != '0) && (occ < 3'd2);
    land_hi = (outcnt == 2'd2) || ((outcnt == 2'd1) && !pop);
    wr_nx = wr_ptr + {{ADDR_WIDTH{1'b0}}, push};
    rd_nx = rd_ptr + {{ADDR_WIDTH{1'b0}}, issue};
    cnt_nx = wr_nx - rd_nx;
    outcnt_nx = outcnt - {1'b0, pop} + {1'b0, rd_pend};
    level_nx = {1'b0, cnt_nx}
             + {{(ADDR_WIDTH+1){1'b0}}, issue}
             + {{ADDR_WIDTH{1'b0}}, outcnt_nx};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_pend <= 1'b0;
      rdy_en  <= 1'b0;
      outcnt  <= 2'd0;
      level   <= '0;
    end else begin
      wr_ptr  <= wr_nx;
      rd_ptr  <= rd_nx;
      rd_pend <= issue;
      rdy_en  <= 1'b1;
      outcnt  <= outcnt_nx;
      level   <= level_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0 <= '0;
      out1 <= '0;
    end else begin
      if (pop && (outcnt == 2'd2))
        out0 <= out1;
      if (rd_pend) begin
        if (land_hi)
          out1 <= ram_dout;
        else
          out0 <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_axis_fifo_ctrl.sv
// Bench for axis_fifo_ctrl: random traffic vs a queue scoreboard,
// plus directed latency, capacity, throughput and reset cases.
module tb_axis_fifo_ctrl;
  localparam int AW = 4;
  localparam int DW = 32;
`ifdef AXIS_FIFO_TLAST_EN
  localparam int RW = DW + 1;
  localparam bit HAS_LAST = 1'b1;
`else
  localparam int RW = DW;
  localparam bit HAS_LAST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_last = 1'b0;
  logic          m_last;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          ram_we;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [RW-1:0] ram_din, ram_dout;
  logic [AW+1:0] level;

  always #5 clk = ~clk;

  axis_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata),
`ifdef AXIS_FIFO_TLAST_EN
    .s_axis_tlast(s_last),
    .m_axis_tlast(m_last),
`endif
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .ram_we(ram_we),
    .ram_waddr(ram_waddr),
    .ram_din(ram_din),
    .ram_raddr(ram_raddr),
    .ram_dout(ram_dout),
    .level(level)
  );

`ifndef AXIS_FIFO_TLAST_EN
  assign m_last = 1'b0;
`endif

  logic [RW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_din;
    ram_dout <= mem[ram_raddr];
  end

  int total = 0;
  int bad = 0;
  int n_pop = 0;
  logic [DW:0] q[$];
  logic [DW:0] last_out;
  logic acc, popd, vld, prev_stall;
  logic [DW-1:0] prev_data;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic sv, input logic [DW-1:0] sd,
                      input logic sl, input logic mr);
    @(negedge clk);
    s_axis_tvalid = sv;
    s_axis_tdata  = sd;
    s_last        = sl;
    m_axis_tready = mr;
    #1;
    if (prev_stall) begin
      chk("stall_v", m_axis_tvalid, 1);
      chk("stall_d", m_axis_tdata, prev_data);
    end
    vld  = m_axis_tvalid;
    acc  = sv & s_axis_tready;
    popd = m_axis_tvalid & mr;
    if (acc) q.push_back({sl & HAS_LAST, sd});
    if (popd) begin
      n_pop++;
      last_out = {m_last, m_axis_tdata};
      if (q.size() == 0) chk("pop_empty", 1, 0);
      else chk("pop_data", last_out, q.pop_front());
    end
    prev_stall = m_axis_tvalid & !mr;
    prev_data  = m_axis_tdata;
    @(posedge clk);
    #1;
    chk("level", level, q.size());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    #1;
    chk("rst_level", level, 0);
    chk("rst_mvalid", m_axis_tvalid, 0);
    q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_sready0", s_axis_tready, 0);
    chk("rel_mvalid", m_axis_tvalid, 0);
    @(posedge clk);
    #1;
    chk("rel_sready1", s_axis_tready, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++)
      step(1'b0, '0, 1'b0, 1'b1);
    chk("drained", q.size(), 0);
  endtask

  initial begin
    int idx, nacc, base, first, lastc, cnt, sent;
    logic cv, mr;
    logic [DW-1:0] cd;
    prev_stall = 1'b0;
    do_reset();

    // single beat latency
    for (int i = 0; i < 5; i++) begin
      step(i == 0, 32'hA5A5_0001, 1'b0, 1'b1);
      chk("single_v", vld, i == 3);
    end

    // capacity with output stalled
    idx = 0;
    nacc = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, idx, 1'b0, 1'b0);
      if (acc) begin idx++; nacc++; end
    end
    chk("cap_acc", nacc, 18);
    chk("cap_level", level, 18);
    chk("cap_sready", s_axis_tready, 0);
    base = n_pop;
    drain();
    chk("cap_drain", n_pop - base, 18);

    // streaming throughput
    idx = 0; first = -1; lastc = -1; cnt = 0;
    for (int c = 0; c < 110; c++) begin
      step(idx < 100, 1000 + idx, 1'b0, 1'b1);
      if (acc) idx++;
      if (popd) begin
        if (first < 0) first = c;
        else chk("gap", c - lastc, 1);
        lastc = c;
        cnt++;
      end
      if (c == 50) chk("steady_lvl", level, 3);
    end
    chk("first_pop", first, 3);
    chk("stream_n", cnt, 100);

    // random traffic
    sent = 0; cv = 1'b0; cd = '0;
    for (int c = 0; c < 20000 && (sent < 1000 || q.size() != 0); c++) begin
      if (!cv && sent < 1000 && $urandom_range(0, 1) == 1) begin
        cv = 1'b1;
        cd = $urandom;
      end
      mr = ($urandom_range(0, 2) != 0);
      step(cv, cd, 1'b0, mr);
      if (acc) begin cv = 1'b0; sent++; end
    end
    chk("rand_sent", sent, 1000);
    chk("rand_left", q.size(), 0);

    // reset with data held
    for (int i = 0; i < 10; i++) step(1'b1, 500 + i, 1'b0, 1'b0);
    chk("pre_rst_lvl", level, 10);
    do_reset();
    step(1'b1, 32'h1234, 1'b0, 1'b0);
    base = n_pop;
    for (int i = 0; i < 10 && n_pop == base; i++)
      step(1'b0, '0, 1'b0, 1'b1);
    chk("rst_first", last_out[DW-1:0], 32'h1234);
    drain();

`ifdef AXIS_FIFO_TLAST_EN
    idx = 0; cnt = 0; base = n_pop;
    for (int c = 0; c < 200 && (idx < 4 || q.size() != 0); c++) begin
      step(idx < 4, 32'hBEEF_0000 + idx, idx == 3,
           $urandom_range(0, 1) == 1);
      if (acc) idx++;
      if (popd && last_out[DW]) cnt++;
    end
    chk("pkt_beats", n_pop - base, 4);
    chk("pkt_lasts", cnt, 1);
    chk("pkt_lastbeat", last_out, {1'b1, 32'hBEEF_0003});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
